// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter sharing the VRAM write port between NUM_REQ valid/ready writers.
// Optional burst lock (req_last) is compiled in with `define VRAM_ARB_BURST_EN.
module vram_write_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned VRAM_SIZE = 14400
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]          req_last_i,
  output logic                        vram_we_o,
  output logic [ADDR_W-1:0]           vram_addr_o,
  output logic [DATA_W-1:0]           vram_wdata_o,
  output logic                        err_oob_o,
  output logic [31:0]                 wr_count_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] SIZE_L = (ADDR_W + 1)'(VRAM_SIZE);

`ifdef VRAM_ARB_BURST_EN
  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   lock_id_q, lock_id_d;
`else
  logic               unused_last;
  assign unused_last = ^req_last_i;
`endif

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_q, err_d;
  logic [31:0]        cnt_q, cnt_d;

  logic [PTR_W-1:0]   win_c;
  logic [PTR_W-1:0]   cand_c;
  logic               found_c;
  logic               xfer_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic [DATA_W-1:0]  sel_data_c;
  logic               sel_last_c;
  logic               in_range_c;

  // Winner selection, grant and next-state computation
  always_comb begin
    win_c       = '0;
    cand_c      = '0;
    found_c     = 1'b0;
    sel_addr_c  = '0;
    sel_data_c  = '0;
    sel_last_c  = 1'b1;
    req_ready_o = '0;
    rr_ptr_d    = rr_ptr_q;
    we_d        = 1'b0;
    err_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
`ifdef VRAM_ARB_BURST_EN
    state_d     = state_q;
    lock_id_d   = lock_id_q;
`endif

    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand_c = PTR_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
      if (!found_c && req_valid_i[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end

`ifdef VRAM_ARB_BURST_EN
    // A held lock ignores everyone else, even while the owner idles
    if (state_q == ST_LOCK) begin
      win_c   = lock_id_q;
      found_c = req_valid_i[lock_id_q];
    end
`endif

    xfer_c = found_c & ~rst;
    if (xfer_c) req_ready_o[win_c] = 1'b1;

    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (PTR_W'(k) == win_c) begin
        sel_addr_c = req_addr_i[k*ADDR_W +: ADDR_W];
        sel_data_c = req_data_i[k*DATA_W +: DATA_W];
        sel_last_c = req_last_i[k];
      end
    end

    in_range_c = ({1'b0, sel_addr_c} < SIZE_L);

    if (xfer_c) begin
      rr_ptr_d = PTR_W'((int'(win_c) + 1) % int'(NUM_REQ));
      we_d     = in_range_c;
      err_d    = ~in_range_c;
      if (in_range_c) begin
        addr_d = sel_addr_c;
        data_d = sel_data_c;
        cnt_d  = cnt_q + 32'd1;
      end
    end

`ifdef VRAM_ARB_BURST_EN
    case (state_q)
      ST_ARB: begin
        if (xfer_c && !sel_last_c) begin
          state_d   = ST_LOCK;
          lock_id_d = win_c;
        end
      end
      ST_LOCK: begin
        if (xfer_c && sel_last_c) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
`else
    sel_last_c = 1'b1;
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
`ifdef VRAM_ARB_BURST_EN
      state_q   <= ST_ARB;
      lock_id_q <= '0;
`endif
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
`ifdef VRAM_ARB_BURST_EN
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
`endif
    end
  end

  assign vram_we_o    = we_q;
  assign vram_addr_o  = addr_q;
  assign vram_wdata_o = data_q;
  assign err_oob_o    = err_q;
  assign wr_count_o   = cnt_q;

endmodule
